seg_bcd_conv: RTL

SEG_BCD_CONV -- requirements
Module: seg_bcd_conv

---
 rtl/seg_bcd_conv.sv | 127 ++++++++++++
 1 files changed

// File: rtl/seg_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module      : seg_bcd_conv
// Description : Sequential 32-bit binary to 8-digit packed BCD converter.
//               Uses one double-dabble step per clock (32 steps). Operands
//               above 99_999_999 skip the conversion and load a fill
//               pattern instead.
// Option      : SEG_BCD_SATURATE_EN - when defined, overflow loads
//               0x99999999 instead of the ERR_DIGIT error pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_bcd_conv #(
   parameter logic [3:0] ERR_DIGIT = 4'hE
) (
   input  logic        CLK,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] bin,
   output logic        busy,
   output logic        done,
   output logic        ovf,
   output logic [31:0] bcd
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [31:0] c_OVF_LIMIT = 32'd99_999_999;
   localparam logic [5:0]  c_LAST_STEP = 6'd31;
`ifdef SEG_BCD_SATURATE_EN
   localparam logic [31:0] c_OVF_PATTERN = 32'h9999_9999;
`else
   localparam logic [31:0] c_OVF_PATTERN = {8{ERR_DIGIT}};
`endif

   state_t      r_state;
   state_t      w_state_nxt;
   logic [5:0]  r_cnt;
   logic [63:0] r_shreg;     // {scratch BCD, operand}
   logic        r_ovf;
   logic [31:0] r_bcd;

   logic        w_accept;
   logic        w_in_ovf;
   logic [63:0] w_adj;
   logic [63:0] w_step;

   assign w_in_ovf = (bin > c_OVF_LIMIT);
   assign w_accept = (r_state == S_IDLE) && start;

   // Add-3 correction on every scratch digit that would overflow a decimal digit when doubled
   for (genvar gi = 0; gi < 8; gi++) begin : g_adj
      assign w_adj[32+4*gi +: 4] = (r_shreg[32+4*gi +: 4] >= 4'd5) ?
                                   (r_shreg[32+4*gi +: 4] + 4'd3) :
                                    r_shreg[32+4*gi +: 4];
   end
   assign w_adj[31:0] = r_shreg[31:0];
   assign w_step      = w_adj << 1;

   // State register
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and status outputs
   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = w_in_ovf ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            busy = 1'b1;
            if (r_cnt == c_LAST_STEP) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath: operand capture, shift steps, and result load on entry to DONE so bcd is valid alongside done
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_shreg <= 64'd0;
         r_cnt   <= 6'd0;
         r_ovf   <= 1'b0;
         r_bcd   <= 32'd0;
      end else if (w_accept) begin
         r_shreg <= {32'd0, bin};
         r_cnt   <= 6'd0;
         r_ovf   <= w_in_ovf;
         if (w_in_ovf) begin
            r_bcd <= c_OVF_PATTERN;
         end
      end else if (r_state == S_SHIFT) begin
         r_shreg <= w_step;
         r_cnt   <= r_cnt + 6'd1;
         if (r_cnt == c_LAST_STEP) begin
            r_bcd <= w_step[63:32];
         end
      end
   end

   assign ovf = r_ovf;
   assign bcd = r_bcd;

endmodule
`default_nettype wire
